data_mem_unit: RTL and testbench

//  Load/store unit feeding the writeback MemToReg select ("memory data" input).

---
 rtl/data_mem_unit_pkg.sv | 15 +
 rtl/data_mem_unit_ram.sv | 30 +++
 rtl/data_mem_unit.sv | 110 +++++++++++
 tb/tb_data_mem_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_unit_pkg.sv
// Shared definitions for the data memory unit: FSM state encodings and the
// default geometry that the core stall logic also relies on.
package data_mem_unit_pkg;

    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_MEM_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_unit_ram.sv
// Single-port synchronous RAM whose read data emerges MEM_LAT clocks after the
// address is presented. Neither the array nor the read pipeline is reset.
module data_mem_ram #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem  [2**ADDR_W];
    logic [DATA_W-1:0] pipe [MEM_LAT];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        pipe[0] <= mem[addr];
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign rdata = pipe[MEM_LAT-1];

endmodule

// File: rtl/data_mem_unit.sv
// Load/store unit: one word-aligned request per handshake, fixed-latency RAM
// access, and a one-cycle response strobe carrying load data to writeback.
module data_mem_unit
    import data_mem_unit_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output state_t            dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both 1; req_ready depends only on state and rst.
    localparam int            CW   = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

    state_t            state;
    logic [CW-1:0]     lat_cnt;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rsp_load;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic              unused_addr;

    assign unused_addr = ^req_addr[31:ADDR_W+2];

    assign req_ready = (state == ST_IDLE) && !rst;
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    // The write belongs to the first ACCESS edge; a coinciding reset cancels it.
    assign ram_we = (state == ST_ACCESS) && (lat_cnt == '0) && we_q && !rst;

    // The RAM output is itself a register, so gating it keeps the response registered.
    assign rsp_rdata = rsp_load ? ram_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            lat_cnt   <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_load  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_load  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        waddr_q <= req_addr[ADDR_W+1:2];
                        wdata_q <= req_wdata;
                        lat_cnt <= '0;
                        if (req_addr[1:0] != 2'b00) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (lat_cnt == LAST) begin
                        state     <= ST_RESP;
                        lat_cnt   <= '0;
                        rsp_valid <= 1'b1;
                        rsp_load  <= !we_q;
                    end else begin
                        lat_cnt <= lat_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    data_mem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .MEM_LAT(MEM_LAT)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (waddr_q),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: three instances at MEM_LAT 1, 2 and 4 share clock
// and reset; expected responses are queued at accept and compared on rsp_valid.
module tb_data_mem_unit;
    import data_mem_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_a [3];
    logic        req_we_a    [3];
    logic [31:0] req_addr_a  [3];
    logic [31:0] req_wdata_a [3];
    logic        req_ready_a [3];
    logic        rsp_valid_a [3];
    logic [31:0] rsp_rdata_a [3];
    logic        rsp_err_a   [3];
    logic        busy_a      [3];
    state_t      dbg_a       [3];

    int checks   = 0;
    int failures = 0;
    int rsp_cnt [3];
    int exp_cnt [3];
    logic [31:0] model_mem [3][1024];
    logic [32:0] exp_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_unit #(
            .ADDR_W (10),
            .DATA_W (32),
            .MEM_LAT(g == 0 ? 1 : (g == 1 ? 2 : 4))
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .req_valid(req_valid_a[g]),
            .req_ready(req_ready_a[g]),
            .req_we   (req_we_a[g]),
            .req_addr (req_addr_a[g]),
            .req_wdata(req_wdata_a[g]),
            .rsp_valid(rsp_valid_a[g]),
            .rsp_rdata(rsp_rdata_a[g]),
            .rsp_err  (rsp_err_a[g]),
            .busy     (busy_a[g]),
            .dbg_state(dbg_a[g])
        );
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid_a[i]) rsp_cnt[i]++;
        end
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_expect(input int k, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata);
        int widx;
        widx = int'(addr[11:2]);
        if (addr[1:0] != 2'b00) begin
            exp_q.push_back({1'b1, 32'h0});
        end else if (we) begin
            model_mem[k][widx] = wdata;
            exp_q.push_back({1'b0, 32'h0});
        end else begin
            exp_q.push_back({1'b0, model_mem[k][widx]});
        end
        exp_cnt[k]++;
    endtask

    task automatic pop_compare(input int k, input string tag);
        logic [32:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected_rsp"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_rdata"}, 64'(rsp_rdata_a[k]), 64'(e[31:0]));
            check({tag, "_err"}, 64'(rsp_err_a[k]), 64'(e[32]));
        end
    endtask

    task automatic do_req(input int k, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag);
        int n;
        int lat;
        int exp_lat;
        @(negedge clk);
        req_valid_a[k] = 1'b1;
        req_we_a[k]    = we;
        req_addr_a[k]  = addr;
        req_wdata_a[k] = wdata;
        n = 0;
        while (!req_ready_a[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, 64'(req_ready_a[k]), 64'd1);
        push_expect(k, we, addr, wdata);
        exp_lat = (addr[1:0] != 2'b00) ? 1 : lat_of(k) + 1;
        @(posedge clk);
        #1;
        req_valid_a[k] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid_a[k] && lat < 50);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        if (rsp_valid_a[k]) pop_compare(k, tag);
        else void'(exp_q.pop_front());
        @(negedge clk);
        check({tag, "_pulse"}, 64'(rsp_valid_a[k]), 64'd0);
    endtask

    task automatic run_burst(input int k);
        logic [31:0] addrs [3];
        int acc;
        int last_acc;
        int cyc;
        int bad_ready;
        addrs[0] = 32'h0000_0010;
        addrs[1] = 32'h0000_1010;
        addrs[2] = 32'h0000_2010;
        acc = 0;
        last_acc = 0;
        cyc = 0;
        bad_ready = 0;
        @(negedge clk);
        req_valid_a[k] = 1'b1;
        req_we_a[k]    = 1'b0;
        req_addr_a[k]  = addrs[0];
        while ((acc < 3 || exp_q.size() > 0) && cyc < 200) begin
            if (busy_a[k] && req_ready_a[k]) bad_ready++;
            if (rsp_valid_a[k]) pop_compare(k, $sformatf("burst%0d", k));
            if (req_valid_a[k] && req_ready_a[k]) begin
                if (acc > 0) check($sformatf("burst%0d_space", k), 64'(cyc - last_acc),
                                   64'(lat_of(k) + 2));
                last_acc = cyc;
                push_expect(k, 1'b0, addrs[acc], 32'h0);
                acc++;
                @(posedge clk);
                #1;
                if (acc < 3) req_addr_a[k] = addrs[acc];
                else req_valid_a[k] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check($sformatf("burst%0d_accepts", k), 64'(acc), 64'd3);
        check($sformatf("burst%0d_ready_while_busy", k), 64'(bad_ready), 64'd0);
        check($sformatf("burst%0d_drained", k), 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            req_valid_a[i] = 1'b0;
            req_we_a[i]    = 1'b0;
            req_addr_a[i]  = 32'h0;
            req_wdata_a[i] = 32'h0;
            rsp_cnt[i]     = 0;
            exp_cnt[i]     = 0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready_low", 64'(req_ready_a[1]), 64'd0);
        check("rst_busy", 64'(busy_a[1]), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid_a[1]), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Scenario 1: idle after reset
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_ready", 64'(req_ready_a[1]), 64'd1);
            check("idle_busy", 64'(busy_a[1]), 64'd0);
            check("idle_rsp_valid", 64'(rsp_valid_a[1]), 64'd0);
        end

        // Scenario 2 across all latencies
        for (int k = 0; k < 3; k++) begin
            do_req(k, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, $sformatf("st%0d", k));
            do_req(k, 1'b0, 32'h0000_0010, 32'h0, $sformatf("ld%0d", k));
        end

        // Scenario 3: misaligned load, then aligned load still intact
        do_req(1, 1'b0, 32'h0000_0013, 32'h0, "misld");
        do_req(1, 1'b1, 32'h0000_0012, 32'h0BAD_0BAD, "misst");
        do_req(1, 1'b0, 32'h0000_0010, 32'h0, "ld_after_mis");

        // Scenario 4: address wrap
        do_req(1, 1'b1, 32'h0000_1004, 32'h1234_5678, "wrap_st");
        do_req(1, 1'b0, 32'h0000_0004, 32'h0, "wrap_ld");

        // Random aligned traffic on word addresses inside a small window
        for (int r = 0; r < 8; r++) begin
            do_req(1, 1'($urandom_range(0, 1)), {20'h0, 6'($urandom_range(8, 15)), 6'h0} | 32'h40,
                   $urandom, $sformatf("rnd%0d", r));
        end

        // Scenario 5 across all latencies
        for (int k = 0; k < 3; k++) run_burst(k);

        // Scenario 6: reset on the store's write edge
        do_req(1, 1'b1, 32'h0000_0020, 32'h1111_2222, "pre_st");
        @(negedge clk);
        req_valid_a[1] = 1'b1;
        req_we_a[1]    = 1'b1;
        req_addr_a[1]  = 32'h0000_0020;
        req_wdata_a[1] = 32'hAAAA_5555;
        check("abort_accept", 64'(req_ready_a[1]), 64'd1);
        @(posedge clk);
        #1;
        req_valid_a[1] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_state", 64'(dbg_a[1]), 64'(ST_IDLE));
        check("abort_ready", 64'(req_ready_a[1]), 64'd1);
        check("abort_busy", 64'(busy_a[1]), 64'd0);
        check("abort_rsp_valid", 64'(rsp_valid_a[1]), 64'd0);
        check("abort_rdata", 64'(rsp_rdata_a[1]), 64'd0);
        check("abort_err", 64'(rsp_err_a[1]), 64'd0);
        repeat (6) @(negedge clk);
        do_req(1, 1'b0, 32'h0000_0020, 32'h0, "ld_after_abort");

        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rsp_count%0d", k), 64'(rsp_cnt[k]), 64'(exp_cnt[k]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
